// File: rtl/mux8_rr_arbiter.sv
// ============================================================================
// Module   : mux8_rr_arbiter
// Purpose  : Arbitrates eight requesters onto one external 8:1 x 16-bit data
//            mux. The winner's index is driven on B, its word is captured from
//            MUX_OUT one cycle later and presented downstream on DOUT/DVALID.
//            The block then holds until DREADY accepts the word.
//            Round-robin arbitration by default. If ARB_FIXED_PRIO_EN is
//            defined, fixed priority is used instead (lowest index wins).
// Ports    : CLK       - clock, rising edge
//            RST       - synchronous active-high reset
//            REQ[7:0]  - level requests, bit i = requester i
//            MUX_OUT   - data returned by the external mux selected by B
//            DREADY    - downstream accept
//            B[2:0]    - mux select (index of granted requester)
//            GNT[7:0]  - one-hot grant, requester holds data while set
//            ACK[7:0]  - one-cycle pulse when the requester's data is taken
//            DOUT      - captured data to downstream
//            DVALID    - DOUT valid
//            XFER_CNT  - completed downstream transfers, wraps silently
// Config   : ARB_FIXED_PRIO_EN (undefined = round-robin)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8_rr_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  REQ,
    input  logic [15:0] MUX_OUT,
    input  logic        DREADY,
    output logic [2:0]  B,
    output logic [7:0]  GNT,
    output logic [7:0]  ACK,
    output logic [15:0] DOUT,
    output logic        DVALID,
    output logic [15:0] XFER_CNT
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_CAPT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_b;
    logic [7:0]  r_gnt;
    logic [7:0]  r_ack;
    logic [15:0] r_dout;
    logic        r_dvalid;
    logic [15:0] r_xfer_cnt;

    logic [2:0]  w_b_nxt;
    logic [7:0]  w_gnt_nxt;
    logic [7:0]  w_ack_nxt;
    logic [15:0] w_dout_nxt;
    logic        w_dvalid_nxt;
    logic [15:0] w_xfer_cnt_nxt;

    logic        w_req_any;
    logic [2:0]  w_winner;

    assign w_req_any = |REQ;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        w_winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (REQ[i]) begin
                w_winner = 3'(i);
            end
        end
    end
`else
    // Index of the requester that completed the most recent capture.
    logic [2:0] r_last;
    logic [2:0] w_scan;

    // Round-robin: offsets 1..8 from r_last, evaluated from the far end so the
    // nearest set bit above r_last overrides. 3-bit addition provides the
    // 7->0 wrap, and offset 8 revisits r_last itself at the lowest priority.
    always_comb begin
        w_winner = 3'd0;
        w_scan   = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            w_scan = r_last + 3'(k);
            if (REQ[w_scan]) begin
                w_winner = w_scan;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last <= 3'd7;
        end else if (r_state == ST_CAPT) begin
            r_last <= r_b;
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_b_nxt        = r_b;
        w_gnt_nxt      = r_gnt;
        w_ack_nxt      = 8'd0;
        w_dout_nxt     = r_dout;
        w_dvalid_nxt   = r_dvalid;
        w_xfer_cnt_nxt = r_xfer_cnt;

        case (r_state)
            ST_ARB: begin
                w_gnt_nxt = 8'd0;
                if (w_req_any) begin
                    w_b_nxt     = w_winner;
                    w_gnt_nxt   = 8'd1 << w_winner;
                    w_state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                // GNT has been up for a full cycle, so MUX_OUT now carries
                // the granted requester's stable word.
                w_dout_nxt   = MUX_OUT;
                w_dvalid_nxt = 1'b1;
                w_ack_nxt    = 8'd1 << r_b;
                w_gnt_nxt    = 8'd0;
                w_state_nxt  = ST_OUT;
            end
            ST_OUT: begin
                if (r_dvalid && DREADY) begin
                    w_dvalid_nxt   = 1'b0;
                    w_xfer_cnt_nxt = r_xfer_cnt + 16'd1;
                    w_state_nxt    = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_ARB;
            r_b        <= 3'd0;
            r_gnt      <= 8'd0;
            r_ack      <= 8'd0;
            r_dout     <= 16'd0;
            r_dvalid   <= 1'b0;
            r_xfer_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_b        <= w_b_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_dout     <= w_dout_nxt;
            r_dvalid   <= w_dvalid_nxt;
            r_xfer_cnt <= w_xfer_cnt_nxt;
        end
    end

    assign B        = r_b;
    assign GNT      = r_gnt;
    assign ACK      = r_ack;
    assign DOUT     = r_dout;
    assign DVALID   = r_dvalid;
    assign XFER_CNT = r_xfer_cnt;

endmodule

`default_nettype wire
